// File: rtl/receptor_ps2.sv
// PS/2 keyboard receiver with a scan-code decoder.
// Both raw PS/2 lines pass through two-flop synchronizers. The clock line is
// then debounced by a shift-register filter. Each falling edge of the filtered
// clock advances an 11-bit frame receiver (start, 8 data LSB-first, odd parity,
// stop). Accepted bytes go to a decoder that strips the E0 (extended) and
// F0 (break) prefixes and reports make/break events.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a start bit (ps2d low on a fall_edge, rx_en high)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking the stop bit and parity, then delivering or flagging
module receptor_ps2 #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2c,
   input  logic       ps2d,
   input  logic       rx_en,
   output logic [7:0] dout,
   output logic       rx_done_tick,
   output logic       frame_err,
   output logic [7:0] key_code,
   output logic       key_make,
   output logic       key_break,
   output logic       key_ext
);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   localparam logic [17:0] TMO_LAST = 18'(TIMEOUT_CYC - 1);

   // synchronizer stages; preset to the idle bus level so reset looks like an idle line
   logic                  c_s1, c_s2;
   logic                  d_s1, d_s2;

   // clock-line glitch filter
   logic [FILTER_LEN-1:0] filt_reg;
   logic                  f_val;
   logic                  f_next;
   logic                  fall_edge;

   // frame receiver
   state_t                state;
   logic [2:0]            bit_cnt;
   logic [7:0]            shreg;
   logic                  par_bit;
   logic [17:0]           tmo_cnt;

   // decoder prefix flags
   logic                  ext_flag;
   logic                  brk_flag;

   // bring both PS/2 lines into the clk domain
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         c_s1 <= 1'b1;
         c_s2 <= 1'b1;
         d_s1 <= 1'b1;
         d_s2 <= 1'b1;
      end else begin
         c_s1 <= ps2c;
         c_s2 <= c_s1;
         d_s1 <= ps2d;
         d_s2 <= d_s1;
      end
   end

   // filtered level changes only once the whole sample window agrees
   always_comb begin
      f_next = f_val;
      if (filt_reg == '1)
         f_next = 1'b1;
      else if (filt_reg == '0)
         f_next = 1'b0;
   end

   // sample window shift, filtered level and registered falling-edge pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         filt_reg  <= '0;
         f_val     <= 1'b0;
         fall_edge <= 1'b0;
      end else begin
         filt_reg  <= {c_s2, filt_reg[FILTER_LEN-1:1]};
         f_val     <= f_next;
         fall_edge <= f_val & ~f_next;
      end
   end

   // frame receiver FSM with idle timeout; fall_edge wins over the timeout
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         shreg        <= '0;
         par_bit      <= 1'b0;
         tmo_cnt      <= '0;
         dout         <= '0;
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
         if (state == IDLE) begin
            tmo_cnt <= '0;
            if (fall_edge && rx_en && !d_s2) begin
               state   <= DATA;
               bit_cnt <= '0;
            end
         end else if (fall_edge) begin
            tmo_cnt <= '0;
            case (state)
               DATA: begin
                  shreg <= {d_s2, shreg[7:1]};
                  if (bit_cnt == 3'd7)
                     state <= PARITY;
                  else
                     bit_cnt <= bit_cnt + 3'd1;
               end
               PARITY: begin
                  par_bit <= d_s2;
                  state   <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (d_s2 && (^{shreg, par_bit})) begin
                     dout         <= shreg;
                     rx_done_tick <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (tmo_cnt == TMO_LAST) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            tmo_cnt   <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + 18'd1;
         end
      end
   end

   // scan-code decoder: prefixes arm flags, any other byte emits a key event
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ext_flag  <= 1'b0;
         brk_flag  <= 1'b0;
         key_code  <= '0;
         key_ext   <= 1'b0;
         key_make  <= 1'b0;
         key_break <= 1'b0;
      end else begin
         key_make  <= 1'b0;
         key_break <= 1'b0;
         if (frame_err) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
         end else if (rx_done_tick) begin
            if (dout == 8'hE0) begin
               ext_flag <= 1'b1;
            end else if (dout == 8'hF0) begin
               brk_flag <= 1'b1;
            end else begin
               key_code  <= dout;
               key_ext   <= ext_flag;
               key_break <= brk_flag;
               key_make  <= ~brk_flag;
               ext_flag  <= 1'b0;
               brk_flag  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_receptor_ps2.sv
// Bench for receptor_ps2: directed and random frames checked against a
// frame-level model of the receiver and decoder.
module tb_receptor_ps2;

   localparam int FL  = 8;
   localparam int TMO = 2000;
   localparam int HP  = 40;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ps2c = 1'b1;
   logic       ps2d = 1'b1;
   logic       rx_en = 1'b1;
   logic [7:0] dout;
   logic       rx_done_tick;
   logic       frame_err;
   logic [7:0] key_code;
   logic       key_make;
   logic       key_break;
   logic       key_ext;

   int checks = 0;
   int errors = 0;

   int cnt_done = 0, cnt_err = 0, cnt_make = 0, cnt_break = 0;

   logic [7:0] m_dout = 8'h00, m_code = 8'h00;
   logic       m_ext = 1'b0, m_ext_flag = 1'b0, m_brk_flag = 1'b0;
   int         m_done = 0, m_err = 0, m_make = 0, m_break = 0;

   receptor_ps2 #(.FILTER_LEN(FL), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
      .dout(dout), .rx_done_tick(rx_done_tick), .frame_err(frame_err),
      .key_code(key_code), .key_make(key_make), .key_break(key_break),
      .key_ext(key_ext)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // pulse counters and mutual-exclusion checks, sampled away from the active edge
   always @(negedge clk) begin
      if (reset) begin
         if (rx_done_tick === 1'b1) cnt_done++;
         if (frame_err === 1'b1) cnt_err++;
         if (key_make === 1'b1) cnt_make++;
         if (key_break === 1'b1) cnt_break++;
         if (rx_done_tick === 1'b1 || frame_err === 1'b1)
            chk("done_err_excl", {31'd0, rx_done_tick & frame_err}, 32'd0);
         if (key_make === 1'b1 || key_break === 1'b1)
            chk("make_break_excl", {31'd0, key_make & key_break}, 32'd0);
      end
   end

   // frame-level model: a complete frame either delivers a byte or is an error
   task automatic model_frame(input logic [7:0] data, input logic good);
      if (good) begin
         m_dout = data;
         m_done++;
         if (data == 8'hE0) m_ext_flag = 1'b1;
         else if (data == 8'hF0) m_brk_flag = 1'b1;
         else begin
            m_code = data;
            m_ext  = m_ext_flag;
            if (m_brk_flag) m_break++;
            else m_make++;
            m_ext_flag = 1'b0;
            m_brk_flag = 1'b0;
         end
      end else begin
         m_err++;
         m_ext_flag = 1'b0;
         m_brk_flag = 1'b0;
      end
   endtask

   task automatic model_reset();
      m_dout = 8'h00; m_code = 8'h00; m_ext = 1'b0;
      m_ext_flag = 1'b0; m_brk_flag = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".dout"}, {24'd0, dout}, {24'd0, m_dout});
      chk({tag, ".key_code"}, {24'd0, key_code}, {24'd0, m_code});
      chk({tag, ".key_ext"}, {31'd0, key_ext}, {31'd0, m_ext});
      chk({tag, ".n_done"}, cnt_done, m_done);
      chk({tag, ".n_err"}, cnt_err, m_err);
      chk({tag, ".n_make"}, cnt_make, m_make);
      chk({tag, ".n_break"}, cnt_break, m_break);
   endtask

   // keyboard side: data changes while the clock is high, clock low for HP cycles
   task automatic send_frame(input logic [7:0] data, input logic bad_par,
                             input logic stop_bit, input int nbits, input int drop_en_at);
      logic [10:0] bits;
      bits = {stop_bit, (~^data) ^ bad_par, data, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         if (i == drop_en_at) rx_en = 1'b0;
         ps2d = bits[i];
         repeat (HP) @(negedge clk);
         ps2c = 1'b0;
         repeat (HP) @(negedge clk);
         ps2c = 1'b1;
      end
      ps2d = 1'b1;
      repeat (HP) @(negedge clk);
   endtask

   initial begin
      logic [7:0] rb;
      logic       bad;

      #1;
      chk("rst.dout", {24'd0, dout}, 32'd0);
      chk("rst.key_code", {24'd0, key_code}, 32'd0);
      chk("rst.pulses", {26'd0, rx_done_tick, frame_err, key_make, key_break, key_ext, 1'b0}, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (30) @(negedge clk);
      check_all("idle");

      send_frame(8'h1C, 1'b0, 1'b1, 11, -1); model_frame(8'h1C, 1'b1);
      check_all("make_1c");

      send_frame(8'hF0, 1'b0, 1'b1, 11, -1); model_frame(8'hF0, 1'b1);
      check_all("brk_f0");
      send_frame(8'h1C, 1'b0, 1'b1, 11, -1); model_frame(8'h1C, 1'b1);
      check_all("brk_1c");

      send_frame(8'hE0, 1'b0, 1'b1, 11, -1); model_frame(8'hE0, 1'b1);
      send_frame(8'h75, 1'b0, 1'b1, 11, -1); model_frame(8'h75, 1'b1);
      check_all("ext_75");
      send_frame(8'h1C, 1'b0, 1'b1, 11, -1); model_frame(8'h1C, 1'b1);
      check_all("plain_after_ext");

      send_frame(8'h1C, 1'b1, 1'b1, 11, -1); model_frame(8'h1C, 1'b0);
      check_all("bad_parity");
      send_frame(8'h3A, 1'b0, 1'b1, 11, -1); model_frame(8'h3A, 1'b1);
      check_all("after_parity_err");

      send_frame(8'h5B, 1'b0, 1'b0, 11, -1); model_frame(8'h5B, 1'b0);
      check_all("bad_stop");

      // an E0 followed by an error must not leave the extended flag armed
      send_frame(8'hE0, 1'b0, 1'b1, 11, -1); model_frame(8'hE0, 1'b1);
      send_frame(8'h12, 1'b1, 1'b1, 11, -1); model_frame(8'h12, 1'b0);
      send_frame(8'h12, 1'b0, 1'b1, 11, -1); model_frame(8'h12, 1'b1);
      check_all("err_clears_ext");

      send_frame(8'hA5, 1'b0, 1'b1, 5, -1);
      repeat (TMO + 100) @(negedge clk);
      m_err++; m_ext_flag = 1'b0; m_brk_flag = 1'b0;
      check_all("timeout");
      send_frame(8'h69, 1'b0, 1'b1, 11, -1); model_frame(8'h69, 1'b1);
      check_all("after_timeout");

      @(negedge clk); ps2d = 1'b0;
      repeat (5) @(negedge clk); ps2c = 1'b0;
      repeat (3) @(negedge clk); ps2c = 1'b1;
      repeat (20) @(negedge clk); ps2d = 1'b1;
      check_all("glitch");
      send_frame(8'h2D, 1'b0, 1'b1, 11, -1); model_frame(8'h2D, 1'b1);
      check_all("after_glitch");

      rx_en = 1'b0;
      send_frame(8'h44, 1'b0, 1'b1, 11, -1);
      check_all("rx_disabled");
      rx_en = 1'b1;
      send_frame(8'h4B, 1'b0, 1'b1, 11, 4); model_frame(8'h4B, 1'b1);
      check_all("rx_en_drop_midframe");
      rx_en = 1'b1;

      for (int n = 0; n < 14; n++) begin
         rb = 8'($urandom);
         case ($urandom_range(0, 7))
            0: rb = 8'hE0;
            1: rb = 8'hF0;
            default: ;
         endcase
         bad = ($urandom_range(0, 3) == 0);
         send_frame(rb, bad, 1'b1, 11, -1);
         model_frame(rb, !bad);
         check_all($sformatf("rand%0d", n));
      end

      send_frame(8'h7E, 1'b0, 1'b1, 11, -1); model_frame(8'h7E, 1'b1);
      send_frame(8'h33, 1'b0, 1'b1, 5, -1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      model_reset();
      chk("midrst.dout", {24'd0, dout}, 32'd0);
      chk("midrst.key_code", {24'd0, key_code}, 32'd0);
      chk("midrst.pulses", {27'd0, rx_done_tick, frame_err, key_make, key_break, key_ext}, 32'd0);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      repeat (30) @(negedge clk);
      send_frame(8'h1C, 1'b0, 1'b1, 11, -1); model_frame(8'h1C, 1'b1);
      check_all("after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/receptor_ps2.md
RECEPTOR_PS2 -- requirements
Module: receptor_ps2

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: number of consecutive equal ps2c samples needed to change the filtered clock.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 200000: idle clk cycles (2 ms at 100 MHz) after which a partial frame is aborted.
REQ-003 SHALL have port clk, input, 1: single system clock, rising edge; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port ps2c, input, 1: raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-006 SHALL have port ps2d, input, 1: raw PS/2 data from the keyboard, asynchronous to clk.
REQ-007 SHALL have port rx_en, input, 1: 1 = accept new frames.
REQ-008 SHALL have port dout, output, 8: last correctly received byte.
REQ-009 SHALL have port rx_done_tick, output, 1: one-cycle pulse when dout is updated.
REQ-010 SHALL have port frame_err, output, 1: one-cycle pulse on parity, stop or timeout error.
REQ-011 SHALL have port key_code, output, 8: last decoded scan code, with E0/F0 prefixes stripped.
REQ-012 SHALL have port key_make, output, 1: one-cycle pulse when a key is pressed.
REQ-013 SHALL have port key_break, output, 1: one-cycle pulse when a key is released.
REQ-014 SHALL have port key_ext, output, 1: key_code was preceded by E0; held until the next key event.

Function
REQ-015 SHALL pass ps2c and ps2d each through a 2-flop synchronizer before any use.
REQ-016 SHALL shift the synchronized ps2c into a FILTER_LEN-bit register each cycle.
REQ-017 SHALL set the filtered clock to 0 only when all FILTER_LEN samples are 0, set it to 1 only when all are 1, and otherwise hold it.
REQ-018 SHALL generate a one-cycle fall_edge pulse on each 1->0 transition of the filtered clock, exactly FILTER_LEN+3 clk edges after a clean ps2c fall.
REQ-019 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-020 In IDLE, on fall_edge with rx_en=1 and synchronized ps2d=0 (start bit), SHALL go to DATA with the bit count cleared; a start bit of 1, or rx_en=0, SHALL leave the FSM in IDLE.
REQ-021 In DATA, SHALL shift synchronized ps2d in LSB-first on each fall_edge, and after the 8th bit SHALL go to PARITY.
REQ-022 In PARITY, SHALL store the parity bit on fall_edge and go to STOP.
REQ-023 In STOP, on fall_edge, SHALL go to IDLE and: if stop=1 and data+parity has odd parity, load dout and pulse rx_done_tick the next cycle; otherwise pulse frame_err and leave dout unchanged.
REQ-024 Outside IDLE, SHALL count clk cycles since the last fall_edge (18-bit counter, cleared on every fall_edge).
REQ-025 When the counter reaches TIMEOUT_CYC-1, SHALL pulse frame_err, go to IDLE and discard partial data.
REQ-026 SHALL give fall_edge priority over the timeout when both occur in the same cycle.
REQ-027 SHALL let a frame already in progress complete normally if rx_en falls mid-frame.
REQ-028 Decoder, on rx_done_tick: if dout=0xE0, SHALL set the ext flag.
REQ-029 Decoder, on rx_done_tick: if dout=0xF0, SHALL set the brk flag.
REQ-030 Decoder, on rx_done_tick with any other dout: SHALL, on the next cycle, load key_code=dout and key_ext=ext, pulse key_break if brk else key_make, and clear both flags.
REQ-031 SHALL clear the ext and brk flags on frame_err.
REQ-032 SHALL never assert key_make and key_break in the same cycle.
REQ-033 SHALL never assert rx_done_tick and frame_err in the same cycle.

Reset
REQ-034 On reset=0, SHALL immediately force FSM=IDLE.
REQ-035 On reset=0, SHALL clear the counters, flags and filter register, and preset both synchronizers to 1 (the idle bus level).
REQ-036 On reset=0, SHALL clear dout, key_code, key_ext, rx_done_tick, frame_err, key_make and key_break to 0.
REQ-037 A reset mid-frame SHALL discard the frame; the first fall_edge after release SHALL be treated as a possible start bit.

Verification
REQ-038 Frame 0x1C (ps2c period 100 us; bits 0,0,0,1,1,1,0,0,0,0,1) -> rx_done_tick once, dout=0x1C, key_make, key_code=0x1C, key_ext=0.
REQ-039 Frames F0 then 1C -> no key pulse after F0; after 1C: key_break, key_code=0x1C, key_make never high.
REQ-040 Frames E0 then 75 -> key_make, key_code=0x75, key_ext=1; a following plain 1C gives key_ext=0.
REQ-041 Frame 0x1C with parity bit 1 -> frame_err once, no rx_done_tick, dout holds its previous value; the next valid frame is received correctly.
REQ-042 Start bit + 4 data bits, then ps2c idle high for 200000 cycles -> frame_err, FSM in IDLE; the next full frame gives correct dout.
REQ-043 A 3-cycle low glitch on ps2c -> no fall_edge, no state change.
REQ-044 Assert reset after 5 bits of a frame -> all outputs 0 immediately; a complete frame after release is received correctly.
